bridge_arbiter: RTL and testbench

BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

---
 rtl/bridge_arbiter_pkg.sv | 17 +
 rtl/bridge_arbiter_hold_counter.sv | 31 +++
 rtl/bridge_arbiter.sv | 144 ++++++++++++++
 tb/tb_bridge_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bridge_arbiter_pkg.sv
// Shared types and constants for the two-master IO bridge arbiter.
package bridge_arbiter_pkg;

    localparam int BUS_W  = 32;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    function automatic logic [STAT_W-1:0] sat_inc_stat(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bridge_arbiter_hold_counter.sv
// Tracks consecutive granted cycles of the current owner; flags when its hold budget is spent.
module arb_hold_counter
    import bridge_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_stay,
    output logic o_limit
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] LIM = CW'(MAX_HOLD - 1);

    logic [CW-1:0] r_cnt;

    // Any grant change or idle cycle restarts the count; it parks at the limit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (i_stay) begin
            r_cnt <= (r_cnt == LIM) ? r_cnt : r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_limit = (r_cnt == LIM);

endmodule

// File: rtl/bridge_arbiter.sv
// Round-robin arbiter with hold-time preemption between CPU (m0) and debug port (m1).
// Optional grant statistics enabled by defining BRIDGE_ARB_STATS_EN.
module bridge_arbiter
    import bridge_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             m0_req,
    input  logic [BUS_W-1:0] m0_addr,
    input  logic             m0_wen,
    input  logic [BUS_W-1:0] m0_wdata,
    input  logic             m1_req,
    input  logic [BUS_W-1:0] m1_addr,
    input  logic             m1_wen,
    input  logic [BUS_W-1:0] m1_wdata,
    output logic             m0_gnt,
    output logic             m1_gnt,
    output logic [BUS_W-1:0] m0_rdata,
    output logic [BUS_W-1:0] m1_rdata,
    output logic [BUS_W-1:0] s_addr,
    output logic             s_wen,
    output logic [BUS_W-1:0] s_wdata,
    input  logic [BUS_W-1:0] s_rdata
`ifdef BRIDGE_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] m0_grant_cnt,
    output logic [STAT_W-1:0] m1_grant_cnt
`endif
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_last_gnt;
    logic       w_limit;
    logic       w_stay;

    assign w_stay = (r_state != IDLE) && (w_next == r_state);

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_stay  (w_stay),
        .o_limit (w_limit)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_next == GNT0 && r_state != GNT0) begin
                r_last_gnt <= 1'b0;
            end else if (w_next == GNT1 && r_state != GNT1) begin
                r_last_gnt <= 1'b1;
            end
        end
    end

    // A master that releases hands straight to a waiting peer, without an idle bubble.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    w_next = r_last_gnt ? GNT0 : GNT1;
                end else if (m0_req) begin
                    w_next = GNT0;
                end else if (m1_req) begin
                    w_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0_req) begin
                    w_next = m1_req ? GNT1 : IDLE;
                end else if (m1_req && w_limit) begin
                    w_next = GNT1;
                end
            end
            GNT1: begin
                if (!m1_req) begin
                    w_next = m0_req ? GNT0 : IDLE;
                end else if (m0_req && w_limit) begin
                    w_next = GNT0;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wen    = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        unique case (r_state)
            GNT0: begin
                m0_gnt   = 1'b1;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wen    = m0_wen & m0_req;
                m0_rdata = s_rdata;
            end
            GNT1: begin
                m1_gnt   = 1'b1;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wen    = m1_wen & m1_req;
                m1_rdata = s_rdata;
            end
            default: ;
        endcase
    end

`ifdef BRIDGE_ARB_STATS_EN
    logic [STAT_W-1:0] r_m0_cnt;
    logic [STAT_W-1:0] r_m1_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_m0_cnt <= '0;
            r_m1_cnt <= '0;
        end else begin
            if (w_next == GNT0 && r_state != GNT0) begin
                r_m0_cnt <= sat_inc_stat(r_m0_cnt);
            end
            if (w_next == GNT1 && r_state != GNT1) begin
                r_m1_cnt <= sat_inc_stat(r_m1_cnt);
            end
        end
    end

    assign m0_grant_cnt = r_m0_cnt;
    assign m1_grant_cnt = r_m1_cnt;
`endif

endmodule

// File: tb/tb_bridge_arbiter.sv
// Scoreboard bench for bridge_arbiter (MAX_HOLD=4); stimulus queues expected bus views, a monitor checks them.
module tb_bridge_arbiter;

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } obs_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_wen = 1'b0, m1_wen = 1'b0;
    logic [31:0] m0_addr = 32'h0000_1000, m1_addr = 32'h0000_2000;
    logic [31:0] m0_wdata = 32'h1111_1111, m1_wdata = 32'h2222_2222;
    logic [31:0] s_rdata = 32'h0;
    logic        m0_gnt, m1_gnt, s_wen;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
`ifdef BRIDGE_ARB_STATS_EN
    logic [15:0] m0_grant_cnt, m1_grant_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    int   ncyc = 0;
    int   m0_writes = 0;
    obs_t exp_q[$];

    bridge_arbiter #(.MAX_HOLD(4)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_wen   (m0_wen),
        .m0_wdata (m0_wdata),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_wen   (m1_wen),
        .m1_wdata (m1_wdata),
        .m0_gnt   (m0_gnt),
        .m1_gnt   (m1_gnt),
        .m0_rdata (m0_rdata),
        .m1_rdata (m1_rdata),
        .s_addr   (s_addr),
        .s_wen    (s_wen),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata)
`ifdef BRIDGE_ARB_STATS_EN
        ,
        .m0_grant_cnt (m0_grant_cnt),
        .m1_grant_cnt (m1_grant_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    // One cycle: drive inputs just after the rising edge, queue the hand-stated grant outcome.
    task automatic cyc(input bit rv, input bit r0, input bit r1, input bit w0, input bit w1,
                       input bit e0, input bit e1);
        obs_t e;
        @(posedge clk_i);
        #1;
        rst_i   = rv;
        m0_req  = r0;
        m1_req  = r1;
        m0_wen  = w0;
        m1_wen  = w1;
        ncyc++;
        s_rdata = 32'h5A00_0000 + ncyc;
        e.g0    = e0;
        e.g1    = e1;
        e.wen   = (e0 & r0 & w0) | (e1 & r1 & w1);
        e.addr  = e0 ? m0_addr : (e1 ? m1_addr : 32'h0);
        e.wdata = e0 ? m0_wdata : (e1 ? m1_wdata : 32'h0);
        e.rd0   = e0 ? s_rdata : 32'h0;
        e.rd1   = e1 ? s_rdata : 32'h0;
        exp_q.push_back(e);
    endtask

    always @(negedge clk_i) begin
        if (s_wen && m0_gnt && s_addr == 32'hFFFF_F060 && s_wdata == 32'h0000_00AA)
            m0_writes++;
        if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = '{m0_gnt, m1_gnt, s_wen, s_addr, s_wdata, m0_rdata, m1_rdata};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL bus_view t=%0t gnt=%b%b/%b%b wen=%b/%b addr=%h/%h wdata=%h/%h rd0=%h/%h rd1=%h/%h (got/exp)",
                         $time, a.g0, a.g1, e.g0, e.g1, a.wen, e.wen, a.addr, e.addr,
                         a.wdata, e.wdata, a.rd0, e.rd0, a.rd1, e.rd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, then m0 alone: granted one cycle after its request.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Fresh reset: tie goes to m0, the next tie to m1.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 1);

        // Continuous contention: 4-cycle runs alternate.
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // m0 writes once, releases, m1 takes over with no bubble.
        m0_addr  = 32'hFFFF_F060;
        m0_wdata = 32'h0000_00AA;
        cyc(0, 1, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Reset hits mid-write of m1: grant and write vanish before the next edge.
        cyc(0, 0, 1, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1, 0, 1);
        cyc(1, 0, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Three grants to m0, two to m1.
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 1, 0);
            cyc(0, 0, 1, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0, 1);
        end
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        checks++;
        if (m0_writes != 1) begin
            errors++;
            $display("FAIL m0_write_once count=%0d required=1", m0_writes);
        end
`ifdef BRIDGE_ARB_STATS_EN
        checks++;
        if (m0_grant_cnt !== 16'd3) begin
            errors++;
            $display("FAIL m0_grant_cnt got=%0d required=3", m0_grant_cnt);
        end
        checks++;
        if (m1_grant_cnt !== 16'd2) begin
            errors++;
            $display("FAIL m1_grant_cnt got=%0d required=2", m1_grant_cnt);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
